pipe_stage_skid: RTL

Parametrised, generalised inter-stage pipeline register for the five-stage core, replacing hand-written per-field stage registers. It carries a packed data bus and a packed control bus with a valid/ready handshake. It supports stall back-pressure, synchronous flush with bubble injection, and an optional 2-entry skid buffer so that up_ready is a registered signal. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 85 ++++++++
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_skid.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage core's inter-stage registers:
// occupancy states, the bubble control word and the packed stage-bus layouts.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int XLEN = 32;

  // Control word; a bubble must leave every write enable deasserted.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       ram_we;
    logic [1:0] npc_sel;
    logic [1:0] rf_wsel;
    logic       rf_we;
  } pipe_ctrl_t;

  localparam int PIPE_CTRL_W = $bits(pipe_ctrl_t);
  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

  localparam int WR_W = 5;

  localparam int IFID_PC_LSB   = 0;
  localparam int IFID_PC4_LSB  = IFID_PC_LSB  + XLEN;
  localparam int IFID_INST_LSB = IFID_PC4_LSB + XLEN;
  localparam int IFID_DATA_W   = IFID_INST_LSB + XLEN;
  localparam int IFID_CTRL_W   = 1;

  localparam int IDEX_RD1_LSB  = 0;
  localparam int IDEX_RD2_LSB  = IDEX_RD1_LSB + XLEN;
  localparam int IDEX_PC4_LSB  = IDEX_RD2_LSB + XLEN;
  localparam int IDEX_IMM_LSB  = IDEX_PC4_LSB + XLEN;
  localparam int IDEX_PC_LSB   = IDEX_IMM_LSB + XLEN;
  localparam int IDEX_DATA_W   = IDEX_PC_LSB  + XLEN;
  localparam int IDEX_CTRL_W   = PIPE_CTRL_W;

  localparam int EXMEM_ALU_LSB    = 0;
  localparam int EXMEM_RD2_LSB    = EXMEM_ALU_LSB    + XLEN;
  localparam int EXMEM_PC4_LSB    = EXMEM_RD2_LSB    + XLEN;
  localparam int EXMEM_PCIMM_LSB  = EXMEM_PC4_LSB    + XLEN;
  localparam int EXMEM_WR_LSB     = EXMEM_PCIMM_LSB  + XLEN;
  localparam int EXMEM_DATA_W     = EXMEM_WR_LSB     + WR_W;
  localparam int EXMEM_CTRL_W     = PIPE_CTRL_W;

  localparam int MEMWB_ALU_LSB = 0;
  localparam int MEMWB_RAM_LSB = MEMWB_ALU_LSB + XLEN;
  localparam int MEMWB_PC4_LSB = MEMWB_RAM_LSB + XLEN;
  localparam int MEMWB_WR_LSB  = MEMWB_PC4_LSB + XLEN;
  localparam int MEMWB_DATA_W  = MEMWB_WR_LSB  + WR_W;
  localparam int MEMWB_CTRL_W  = PIPE_CTRL_W;

  function automatic logic [IDEX_DATA_W-1:0] idex_pack(
    input logic [XLEN-1:0] rd1,
    input logic [XLEN-1:0] rd2,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pc
  );
    return {pc, imm, pc4, rd2, rd1};
  endfunction

  function automatic logic [EXMEM_DATA_W-1:0] exmem_pack(
    input logic [XLEN-1:0] alu_y,
    input logic [XLEN-1:0] rd2,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] pc_imm,
    input logic [WR_W-1:0] wr
  );
    return {wr, pc_imm, pc4, rd2, alu_y};
  endfunction

  function automatic logic [MEMWB_DATA_W-1:0] memwb_pack(
    input logic [XLEN-1:0] alu_y,
    input logic [XLEN-1:0] ram_rd,
    input logic [XLEN-1:0] pc4,
    input logic [WR_W-1:0] wr
  );
    return {wr, pc4, ram_rd, alu_y};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage register with valid/ready handshake, flush-to-bubble and an
// optional second (skid) entry that lets up_ready be decoded from state alone.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 160,
  parameter int                 CTRL_W      = 10,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE),
  parameter int                 SKID        = 1,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;

  logic w_dn_valid;
  logic w_up_ready;
  logic w_up_fire;
  logic w_dn_fire;
  logic w_stall;

  assign w_dn_valid = (r_state != ST_EMPTY);

  generate
    if (SKID != 0) begin : g_skid
      assign w_up_ready = !rst && (r_state != ST_FULL);
    end else begin : g_noskid
      // Without a skid entry the stage can only accept when its entry leaves this cycle.
      assign w_up_ready = !rst && (!w_dn_valid || dn_ready);
    end
  endgenerate

  assign w_up_fire = up_valid && w_up_ready;
  assign w_dn_fire = w_dn_valid && dn_ready;
  assign w_stall   = w_dn_valid && !dn_ready && !flush;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      // Data is left alone; only control must drop to a bubble.
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = CTRL_BUBBLE;
      w_skid_ctrl_nxt = CTRL_BUBBLE;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_up_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = up_data;
            w_main_ctrl_nxt = up_ctrl;
          end
        end
        ST_ONE: begin
          if (w_up_fire && w_dn_fire) begin
            w_main_data_nxt = up_data;
            w_main_ctrl_nxt = up_ctrl;
          end else if (w_up_fire) begin
            w_state_nxt     = ST_FULL;
            w_skid_data_nxt = up_data;
            w_skid_ctrl_nxt = up_ctrl;
          end else if (w_dn_fire) begin
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = CTRL_BUBBLE;
          end
        end
        ST_FULL: begin
          if (w_dn_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_skid_ctrl_nxt = CTRL_BUBBLE;
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = CTRL_BUBBLE;
          w_skid_ctrl_nxt = CTRL_BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .i_clr(rst),
    .i_inc(w_stall),
    .o_cnt(stall_cnt)
  );

  assign up_ready = w_up_ready;
  assign dn_valid = w_dn_valid;
  assign dn_data  = r_main_data;
  assign dn_ctrl  = r_main_ctrl;
  assign level    = r_state;

endmodule
